isl51002_line_capture: RTL

// - Downstream of the ISL51002 frontend: captures active, sample-selected pixels (DE_i & datavalid_i) of each line into a
//   two-bank ping-pong line RAM and streams completed lines to the scaler over a valid/ready interface.
// - Decouples the frontend's burst timing (one line in H_ACTIVE) from scaler backpressure; flags dropped lines.

---
 rtl/isl51002_lc_pkg.sv | 33 +++
 rtl/isl51002_line_capture_ram.sv | 29 ++
 rtl/isl51002_line_capture.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/isl51002_lc_pkg.sv
// isl51002_lc_pkg: shared types for the ISL51002 line capture block.
// Pixel/length widths, FSM encodings and the per-bank line descriptor.
package isl51002_lc_pkg;

   localparam int PIX_W = 24;
   localparam int LEN_W = 11;
   localparam int Y_W   = 11;

   typedef enum logic [1:0] {
      WR_WAIT_DE_LOW,
      WR_IDLE,
      WR_CAPTURE,
      WR_DROP
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_PRIME,
      RD_STREAM
   } rd_state_t;

   typedef struct packed {
      logic [LEN_W-1:0] len;
      logic [Y_W-1:0]   y;
      logic             fid;
      logic             full;
   } line_desc_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/isl51002_line_capture_ram.sv
// lc_sdp_ram: simple dual-port line RAM, one write and one registered read port.
// Address is {bank, pixel index}; the read register holds while rd_en is low.
module lc_sdp_ram
   import isl51002_lc_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic             PCLK_i,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [PIX_W-1:0] rd_data
);

   logic [PIX_W-1:0] mem [2**AW];

   always_ff @(posedge PCLK_i) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge PCLK_i) begin
      if (reset) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/isl51002_line_capture.sv
// isl51002_line_capture: ping-pong line buffer between the ISL51002
// frontend and the scaler, with drop accounting per frame.
module isl51002_line_capture
   import isl51002_lc_pkg::*;
#(
   parameter int MAX_LINE_W = 1024,
   parameter int ADDR_W     = 10
) (
   input  logic             PCLK_i,
   input  logic             reset,
   input  logic [7:0]       R_i,
   input  logic [7:0]       G_i,
   input  logic [7:0]       B_i,
   input  logic             DE_i,
   input  logic             datavalid_i,
   input  logic             VSYNC_i,
   input  logic             FID_i,
   input  logic [Y_W-1:0]   ypos_i,
   output logic [PIX_W-1:0] pix_data_o,
   output logic             pix_valid_o,
   input  logic             pix_ready_i,
   output logic             pix_sol_o,
   output logic             pix_eol_o,
   output logic [Y_W-1:0]   line_y_o,
   output logic             line_fid_o,
   output logic             frame_start_o,
   output logic             overflow_o,
   output logic [7:0]       lines_dropped_o
);

   wr_state_t        wr_state, wr_next;
   rd_state_t        rd_state, rd_next;
   line_desc_t       desc [2];
   line_desc_t       rd_desc;
   logic             wr_ptr, rd_ptr;
   logic [LEN_W-1:0] wr_cnt, rd_idx;
   logic [Y_W-1:0]   cap_y;
   logic             cap_fid;
   logic             vs_q, fs_q, ovf;
   logic [7:0]       drop_cnt;
   logic             start, drop, commit, wr_en;
   logic             rd_en, accept, free;
   logic             bank_free, room, fs;
   logic [ADDR_W-1:0] rd_lo;

   assign rd_desc     = desc[rd_ptr];
   assign pix_valid_o = (rd_state == RD_STREAM);
   assign pix_sol_o   = pix_valid_o && (rd_idx == '0);
   assign pix_eol_o   = pix_valid_o &&
                        (rd_idx == rd_desc.len - LEN_W'(1));
   assign accept      = pix_valid_o && pix_ready_i;
   assign free        = accept && pix_eol_o;
   // A bank released this very cycle may be reused by a new line.
   assign bank_free   = !desc[wr_ptr].full ||
                        (free && (rd_ptr == wr_ptr));
   assign room        = wr_cnt < LEN_W'(MAX_LINE_W);
   assign fs          = vs_q && !VSYNC_i;

   assign line_y_o        = rd_desc.y;
   assign line_fid_o      = rd_desc.fid;
   assign frame_start_o   = fs_q;
   assign overflow_o      = ovf;
   assign lines_dropped_o = drop_cnt;

   always_comb begin
      wr_next = wr_state;
      start   = 1'b0;
      drop    = 1'b0;
      commit  = 1'b0;
      wr_en   = 1'b0;
      unique case (wr_state)
         WR_WAIT_DE_LOW: begin
            if (!DE_i) wr_next = WR_IDLE;
         end
         WR_IDLE: begin
            if (DE_i && bank_free) begin
               wr_next = WR_CAPTURE;
               start   = 1'b1;
               wr_en   = datavalid_i;
            end else if (DE_i) begin
               wr_next = WR_DROP;
               drop    = 1'b1;
            end
         end
         WR_CAPTURE: begin
            if (!DE_i) begin
               wr_next = WR_IDLE;
               commit  = (wr_cnt != '0);
            end else begin
               wr_en = datavalid_i && room;
            end
         end
         WR_DROP: begin
            if (!DE_i) wr_next = WR_IDLE;
         end
         default: wr_next = WR_WAIT_DE_LOW;
      endcase
   end

   always_ff @(posedge PCLK_i) begin
      if (reset) begin
         wr_state <= WR_WAIT_DE_LOW;
         wr_ptr   <= 1'b0;
         wr_cnt   <= '0;
         cap_y    <= '0;
         cap_fid  <= 1'b0;
      end else begin
         wr_state <= wr_next;
         if (start) begin
            cap_y   <= ypos_i;
            cap_fid <= FID_i;
         end
         if (!DE_i) wr_cnt <= '0;
         else if (wr_en) wr_cnt <= wr_cnt + LEN_W'(1);
         if (commit) wr_ptr <= ~wr_ptr;
      end
   end

   always_ff @(posedge PCLK_i) begin
      if (reset) begin
         desc[0] <= '0;
         desc[1] <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (commit && (wr_ptr == 1'(b))) begin
               desc[b].len  <= wr_cnt;
               desc[b].y    <= cap_y;
               desc[b].fid  <= cap_fid;
               desc[b].full <= 1'b1;
            end else if (free && (rd_ptr == 1'(b))) begin
               desc[b].full <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rd_next = rd_state;
      rd_en   = 1'b0;
      rd_lo   = rd_idx[ADDR_W-1:0] + ADDR_W'(1);
      unique case (rd_state)
         RD_IDLE: begin
            if (rd_desc.full) rd_next = RD_PRIME;
         end
         RD_PRIME: begin
            rd_next = RD_STREAM;
            rd_en   = 1'b1;
            rd_lo   = '0;
         end
         RD_STREAM: begin
            if (free) rd_next = RD_IDLE;
            else rd_en = accept;
         end
         default: rd_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge PCLK_i) begin
      if (reset) begin
         rd_state <= RD_IDLE;
         rd_ptr   <= 1'b0;
         rd_idx   <= '0;
      end else begin
         rd_state <= rd_next;
         if (rd_state == RD_PRIME) rd_idx <= '0;
         else if (accept && !pix_eol_o) rd_idx <= rd_idx + LEN_W'(1);
         if (free) rd_ptr <= ~rd_ptr;
      end
   end

   // Frame start wins over the sticky flags; a same-cycle drop still counts.
   always_ff @(posedge PCLK_i) begin
      if (reset) begin
         vs_q     <= 1'b0;
         fs_q     <= 1'b0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         vs_q <= VSYNC_i;
         fs_q <= fs;
         if (fs) begin
            ovf      <= drop;
            drop_cnt <= {7'd0, drop};
         end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
         end
      end
   end

   lc_sdp_ram #(
      .AW(ADDR_W + 1)
   ) u_ram (
      .PCLK_i (PCLK_i),
      .reset  (reset),
      .wr_en  (wr_en),
      .wr_addr({wr_ptr, wr_cnt[ADDR_W-1:0]}),
      .wr_data({R_i, G_i, B_i}),
      .rd_en  (rd_en),
      .rd_addr({rd_ptr, rd_lo}),
      .rd_data(pix_data_o)
   );

endmodule
